// File: rtl/wlan_interleaver_pp.sv
// wlan_interleaver_pp: 802.11a block (de)interleaver, 1 bit/clk, two-bank ping-pong buffer.
module wlan_interleaver_pp #(
  parameter int MAX_NCBPS = 288,
  parameter int ADDR_W    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_i,
  input  logic       deint_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       in_bit_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_bit_o,
  output logic       out_last_o
);
  typedef logic [ADDR_W+1:0] wide_t;
  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_st_e;

  function automatic wide_t ncbps(input logic [1:0] m);
    return m == 2'd3 ? wide_t'(288) : wide_t'(48) << m;
  endfunction

  // floor(i/q) always equals k mod 16 because floor(k/16) < q.
  function automatic logic [ADDR_W-1:0] perm(input logic [1:0] m, input logic [ADDR_W-1:0] k);
    wide_t q, i, r;
    q = m == 2'd3 ? wide_t'(18) : wide_t'(3) << m;
    i = q * wide_t'(k[3:0]) + wide_t'(k >> 4);
    r = i + wide_t'(288) - wide_t'(k[3:0]);
    return ADDR_W'(m == 2'd3 ? wide_t'(3) * (i / wide_t'(3)) + r % wide_t'(3) :
                   m == 2'd2 ? {i[ADDR_W+1:1], i[0] ^ k[0]} : i);
  endfunction

  bank_st_e             st_q [2];
  logic [1:0]           mode_q [2];
  logic                 deint_q [2];
  logic [MAX_NCBPS-1:0] bank_q [2];
  logic                 wr_sel_q, rd_sel_q;
  logic [ADDR_W-1:0]    k_q, n_q;
  logic                 out_valid_q, out_bit_q, out_last_q;

  logic              wr_new, wr_deint, wr_acc, wr_last, rd_deint, rd_load, rd_last;
  logic [1:0]        wr_mode, rd_mode;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // The first bit of a symbol uses the live mode inputs; later bits use the latched tag.
  assign wr_new     = st_q[wr_sel_q] == EMPTY;
  assign wr_mode    = wr_new ? mode_i : mode_q[wr_sel_q];
  assign wr_deint   = wr_new ? deint_i : deint_q[wr_sel_q];
  assign in_ready_o = !rst && (wr_new || st_q[wr_sel_q] == FILL);
  assign wr_acc     = in_valid_i && in_ready_o;
  assign wr_last    = wide_t'(k_q) == ncbps(wr_mode) - wide_t'(1);
  assign wr_addr    = wr_deint ? k_q : perm(wr_mode, k_q);
  assign rd_mode    = mode_q[rd_sel_q];
  assign rd_deint   = deint_q[rd_sel_q];
  assign rd_load    = (st_q[rd_sel_q] == FULL || st_q[rd_sel_q] == DRAIN) && (!out_valid_q || out_ready_i);
  assign rd_last    = wide_t'(n_q) == ncbps(rd_mode) - wide_t'(1);
  assign rd_addr    = rd_deint ? perm(rd_mode, n_q) : n_q;

  assign out_valid_o = out_valid_q;
  assign out_bit_o   = out_bit_q;
  assign out_last_o  = out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= '{EMPTY, EMPTY};
      mode_q      <= '{2'd0, 2'd0};
      deint_q     <= '{1'b0, 1'b0};
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      k_q         <= '0;
      n_q         <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_new) begin
          mode_q[wr_sel_q]  <= mode_i;
          deint_q[wr_sel_q] <= deint_i;
        end
        st_q[wr_sel_q] <= wr_last ? FULL : FILL;
        k_q            <= wr_last ? '0 : k_q + 1'b1;
        wr_sel_q       <= wr_sel_q ^ wr_last;
      end
      if (rd_load) begin
        out_valid_q    <= 1'b1;
        out_bit_q      <= bank_q[rd_sel_q][rd_addr];
        out_last_q     <= rd_last;
        st_q[rd_sel_q] <= rd_last ? EMPTY : DRAIN;
        n_q            <= rd_last ? '0 : n_q + 1'b1;
        rd_sel_q       <= rd_sel_q ^ rd_last;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk)
    if (wr_acc) bank_q[wr_sel_q][wr_addr] <= in_bit_i;
endmodule

// File: tb/tb_wlan_interleaver_pp.sv
// tb_wlan_interleaver_pp: scoreboard bench with a formula-level permutation model.
module tb_wlan_interleaver_pp;
  logic clk = 0, rst = 1;
  logic [1:0] mode_i = 0;
  logic deint_i = 0, in_valid_i = 0, in_bit_i = 0, out_ready_i = 1;
  logic in_ready_o, out_valid_o, out_bit_o, out_last_o;

  wlan_interleaver_pp dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .deint_i(deint_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_bit_i(in_bit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_bit_o(out_bit_o), .out_last_o(out_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic b; logic l;} exp_t;
  exp_t sb[$];
  logic hist[$];
  int checks = 0, failures = 0, stalls = 0;
  logic prev_stall = 0, prev_bit = 0, prev_last = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nbits_of(input int m);
    int nb;
    nb = m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 6;
    return 48 * nb;
  endfunction

  // Straight from the standard: i from k, then j from i.
  function automatic int jmap(input int m, input int k);
    int n, nb, s, q, i;
    n  = nbits_of(m);
    nb = n / 48;
    s  = nb / 2 > 1 ? nb / 2 : 1;
    q  = n / 16;
    i  = q * (k % 16) + k / 16;
    return s * (i / s) + (i + n - i / q) % s;
  endfunction

  function automatic logic [287:0] rand288();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int onehot_pos();
    int pos, cnt;
    pos = -1; cnt = 0;
    foreach (hist[i]) if (hist[i]) begin cnt++; pos = i; end
    return cnt == 1 ? pos : -1;
  endfunction

  function automatic logic [287:0] pack_hist();
    logic [287:0] v;
    v = '0;
    foreach (hist[i]) if (i < 288) v[i] = hist[i];
    return v;
  endfunction

  task automatic send_sym(input logic [1:0] m, input logic d, input logic [287:0] b, input int nbits);
    int n, lim, t;
    logic acc;
    logic [287:0] o;
    n = nbits_of(int'(m));
    lim = nbits < n ? nbits : n;
    for (int k = 0; k < lim; k++) begin
      mode_i = k == 0 ? m : 2'($urandom);
      deint_i = k == 0 ? d : 1'($urandom);
      in_bit_i = b[k];
      in_valid_i = 1;
      acc = 0; t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready_o;
        if (!acc) stalls++;
        @(posedge clk); #1;
        if (++t > 4000) begin
          $display("FAIL send_timeout: got %0d expected %0d", t, 4000);
          $fatal(1);
        end
      end
    end
    in_valid_i = 0;
    if (lim == n) begin
      o = '0;
      for (int k = 0; k < n; k++)
        if (d) o[k] = b[jmap(int'(m), k)];
        else o[jmap(int'(m), k)] = b[k];
      for (int i = 0; i < n; i++) sb.push_back('{o[i], logic'(i == n - 1)});
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid_o) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", int'(t < 5000), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_stall <= 0;
    else begin
      if (prev_stall && out_valid_o) begin
        check("stall_bit", out_bit_o, prev_bit);
        check("stall_last", out_last_o, prev_last);
      end
      prev_stall <= out_valid_o && !out_ready_i;
      prev_bit <= out_bit_o;
      prev_last <= out_last_o;
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_bit", out_bit_o, e.b);
          check("out_last", out_last_o, e.l);
        end
        hist.push_back(out_bit_o);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got %0d expected %0d", 1, 0);
    $fatal(1);
  end

  initial begin
    int t2k[3] = '{1, 16, 47};
    int t2p[3] = '{3, 1, 47};
    int t3m[4] = '{2, 3, 2, 3};
    int t3k[4] = '{1, 1, 0, 0};
    int t3p[4] = '{13, 20, 0, 0};
    logic [287:0] v, r, x;
    int gaps, t;
    logic done;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready_o, 1);
    check("post_rst_out_valid", out_valid_o, 0);
    @(posedge clk); #1;

    for (int c = 0; c < 3; c++) begin
      v = '0; v[t2k[c]] = 1; hist.delete();
      send_sym(2'd0, 1'b0, v, 288);
      check("latency_pre", out_valid_o, 0);
      @(posedge clk); #1;
      check("latency_post", out_valid_o, 1);
      wait_drain();
      check("bpsk_pos", onehot_pos(), t2p[c]);
    end

    for (int c = 0; c < 4; c++) begin
      v = '0; v[t3k[c]] = 1; hist.delete();
      send_sym(2'(t3m[c]), 1'b0, v, 288);
      wait_drain();
      check("qam_pos", onehot_pos(), t3p[c]);
    end

    v = '0; v[13] = 1; hist.delete();
    send_sym(2'd2, 1'b1, v, 288);
    wait_drain();
    check("deint_pos", onehot_pos(), 1);

    r = rand288(); hist.delete();
    send_sym(2'd3, 1'b0, r, 288);
    wait_drain();
    x = pack_hist(); hist.delete();
    send_sym(2'd3, 1'b1, x, 288);
    wait_drain();
    check("roundtrip", int'(pack_hist() == r), 1);

    stalls = 0; gaps = 0; t = 0;
    fork
      for (int s = 0; s < 3; s++) send_sym(2'd1, 1'b0, rand288(), 288);
      begin
        while (!out_valid_o && t < 2000) begin @(negedge clk); t++; end
        for (int i = 1; i < 288; i++) begin
          @(negedge clk);
          if (!out_valid_o) gaps++;
        end
      end
    join
    check("gapless_start", int'(t < 2000), 1);
    check("gaps", gaps, 0);
    check("in_stalls", stalls, 0);
    wait_drain();

    out_ready_i = 0;
    send_sym(2'd0, 1'b0, rand288(), 288);
    send_sym(2'd3, 1'b0, rand288(), 288);
    @(negedge clk);
    check("bp_in_ready", in_ready_o, 0);
    check("bp_out_valid", out_valid_o, 1);
    repeat (10) @(posedge clk);
    #1 out_ready_i = 1;
    wait_drain();

    done = 0;
    fork
      begin
        for (int s = 0; s < 6; s++) send_sym(2'($urandom), 1'($urandom), rand288(), 288);
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready_i = 1'($urandom);
      end
    join
    out_ready_i = 1;
    wait_drain();

    out_ready_i = 0;
    send_sym(2'd0, 1'b0, rand288(), 288);
    send_sym(2'd3, 1'b0, rand288(), 100);
    @(negedge clk);
    check("pre_rst_valid", out_valid_o, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_in_ready", in_ready_o, 0);
    check("midrst_last", out_last_o, 0);
    check("midrst_bit", out_bit_o, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    out_ready_i = 1;
    v = '0; v[1] = 1; hist.delete();
    send_sym(2'd0, 1'b0, v, 288);
    wait_drain();
    check("post_rst_pos", onehot_pos(), 3);
    check("post_rst_count", hist.size(), 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
